// File: rtl/im_loader_if.sv
// Loader bus: load request, word stream from the source, byte-write port into
// instruction memory, and CPU hold/status back to the system.
interface im_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [8:0]        word_count;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [8:0]        words_loaded;

  // System / source side
  modport master (
    output start, base_addr, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err,
           words_loaded
  );

  // Loader side
  modport slave (
    input  start, base_addr, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err,
           words_loaded
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: accepts 32-bit words from a valid/ready source and
// writes each as four little-endian bytes into the byte-wide store, holding the CPU meanwhile.
module im_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic       clk,
  input  logic       rst,
  im_loader_if.slave bus
);

  localparam int unsigned CNT_W = 9;
  // Wide enough for base_addr + 4*word_count without overflow
  localparam int unsigned SUM_W = ((ADDR_W > CNT_W + 2) ? ADDR_W : CNT_W + 2) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state;
  state_t            state_d;

  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W-1:0] addr_ptr_d;
  logic [CNT_W-1:0]  wc;
  logic [CNT_W-1:0]  wc_d;
  logic [CNT_W-1:0]  wl;
  logic [CNT_W-1:0]  wl_d;
  logic [31:0]       data_q;
  logic [31:0]       data_d;
  logic [1:0]        lane;
  logic [1:0]        lane_d;

  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              cpu_hold_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              in_ready_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              cpu_hold_d;
  logic              busy_d;
  logic              done_d;
  logic              err_d;

  logic [SUM_W-1:0]  req_end;
  logic              req_zero;
  logic              req_bad;
  logic              last_byte;
  logic              last_word;

  // Request qualification and end-of-word / end-of-load decode
  always_comb begin
    req_end   = SUM_W'(bus.base_addr) + SUM_W'({bus.word_count, 2'b00});
    req_zero  = (bus.word_count == '0);
    req_bad   = (32'(bus.word_count) > MAX_WORDS) ||
                (req_end > (SUM_W'(1) << ADDR_W));
    last_byte = (lane == 2'd3);
    last_word = ((wl + CNT_W'(1)) == wc);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (req_zero) begin
            state_d = FINISH;
          end else if (!req_bad) begin
            state_d = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (last_byte) begin
          state_d = last_word ? FINISH : ACCEPT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered from the next state
  always_comb begin
    addr_ptr_d = addr_ptr;
    wc_d       = wc;
    wl_d       = wl;
    data_d     = data_q;
    lane_d     = lane;
    err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (req_zero) begin
            wc_d = '0;
            wl_d = '0;
          end else if (req_bad) begin
            err_d = 1'b1;
          end else begin
            addr_ptr_d = bus.base_addr;
            wc_d       = bus.word_count;
            wl_d       = '0;
          end
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          data_d = bus.in_data;
          lane_d = 2'd0;
        end
      end
      WRITE: begin
        lane_d = lane + 2'd1;
        if (last_byte) begin
          addr_ptr_d = addr_ptr + ADDR_W'(4);
          wl_d       = wl + CNT_W'(1);
        end
      end
      default: ;
    endcase

    in_ready_d  = (state_d == ACCEPT);
    mem_we_d    = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    cpu_hold_d  = busy_d;
    done_d      = (state_d == FINISH);
    mem_addr_d  = mem_we_d ? (addr_ptr_d + ADDR_W'(lane_d)) : '0;
    mem_wdata_d = mem_we_d ? data_d[{lane_d, 3'b000} +: 8] : 8'h00;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ptr    <= '0;
      wc          <= '0;
      wl          <= '0;
      data_q      <= '0;
      lane        <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_ptr    <= addr_ptr_d;
      wc          <= wc_d;
      wl          <= wl_d;
      data_q      <= data_d;
      lane        <= lane_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_hold     = cpu_hold_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.words_loaded = wl;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: random loads against a byte-image reference model, plus
// directed error, zero-length, reset-abort and start-while-busy cases.
module tb_im_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 256;
  localparam int          MEM_SZ    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] exp_mem [MEM_SZ];
  logic [7:0] act_mem [MEM_SZ];
  int checks   = 0;
  int errors   = 0;
  int nwrites  = 0;
  int ndone    = 0;
  int nerr     = 0;
  int hold_run = 0;
  int max_hold = 0;

  // Byte-array model of the store plus event counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.mem_we) begin
        act_mem[bus.mem_addr] = bus.mem_wdata;
        nwrites++;
      end
      if (bus.done) ndone++;
      if (bus.err) nerr++;
      if (bus.cpu_hold) hold_run++;
      else hold_run = 0;
      if (hold_run > max_hold) max_hold = hold_run;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_hold,
                bus.busy, bus.done, bus.err, bus.words_loaded});
  endfunction

  task automatic mem_cmp(input string tag);
    int bad;
    bad = 0;
    for (int j = 0; j < MEM_SZ; j++) begin
      if (act_mem[j] !== exp_mem[j]) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  // One load: words presented after random gaps, byte stream checked per cycle
  task automatic run_load(input logic [ADDR_W-1:0] base, input int wc, input int gap_lo,
                          input int gap_hi, input logic [31:0] first_word, input bit stray,
                          input int abort_word);
    int w0, d0, e0, gap;
    logic [31:0] w;
    logic [ADDR_W-1:0] a;
    bit ok, got, stop;
    w0 = nwrites; d0 = ndone; e0 = nerr; ok = 1'b1; stop = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = 9'(wc);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base_addr = ADDR_W'($urandom); bus.word_count = 9'($urandom);
    @(negedge clk);
    chk("hold_on", 64'({bus.cpu_hold, bus.busy, bus.in_ready}), 64'h7);
    chk("wl_clr", 64'(bus.words_loaded), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < wc && ok && !stop; i++) begin
      w   = (i == 0) ? first_word : $urandom;
      gap = (stray && i == 1) ? 1 : int'($urandom_range(gap_hi, gap_lo));
      for (int g = 0; g < gap; g++) begin
        if (stray && i == 1 && g == 0) begin
          bus.start = 1'b1; bus.word_count = 9'd1; bus.base_addr = base;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.in_valid = 1'b1; bus.in_data = w; got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (bus.in_ready) got = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      chk("accept", 64'(got), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_data = $urandom;
      if (!got) ok = 1'b0;
      for (int k = 0; k < 4 && ok && !stop; k++) begin
        if (i == abort_word && k == 1) begin
          rst = 1'b1; #1;
          chk("rst_now", outs(), 64'd0);
          repeat (2) @(posedge clk);
          #1 rst = 1'b0;
          stop = 1'b1;
        end else begin
          a = base + ADDR_W'(4 * i + k);
          exp_mem[a] = w[8*k +: 8];
          @(negedge clk);
          chk("we", 64'(bus.mem_we), 64'd1);
          chk("addr", 64'(bus.mem_addr), 64'(a));
          chk("wdata", 64'(bus.mem_wdata), 64'(exp_mem[a]));
          chk("rdy_lo", 64'(bus.in_ready), 64'd0);
          @(posedge clk); #1;
        end
      end
      if (ok && !stop) begin
        @(negedge clk);
        if (i == wc - 1) chk("done", 64'(bus.done), 64'd1);
        else chk("rdy_hi", 64'(bus.in_ready), 64'd1);
        chk("hold_mid", 64'(bus.cpu_hold), 64'd1);
        @(posedge clk); #1;
      end
    end
    if (stop) begin
      repeat (5) @(posedge clk);
      #1;
      chk("abort_wr", 64'(nwrites - w0), 64'(4 * abort_word + 1));
      chk("abort_done", 64'(ndone - d0), 64'd0);
    end else begin
      @(negedge clk);
      chk("idle_after", 64'({bus.busy, bus.cpu_hold, bus.done}), 64'd0);
      chk("wl", 64'(bus.words_loaded), 64'(wc));
      chk("wr_cnt", 64'(nwrites - w0), 64'(4 * wc));
      chk("done_cnt", 64'(ndone - d0), 64'd1);
      chk("err_cnt", 64'(nerr - e0), 64'd0);
      @(posedge clk); #1;
    end
    mem_cmp("mem_img");
  endtask

  task automatic run_bad(input logic [ADDR_W-1:0] base, input int wc);
    int w0;
    w0 = nwrites;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = 9'(wc);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("err_pulse", 64'({bus.err, bus.busy, bus.cpu_hold}), 64'h4);
    @(negedge clk);
    chk("err_clr", 64'({bus.err, bus.busy, bus.cpu_hold}), 64'd0);
    chk("err_wr", 64'(nwrites - w0), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_zero();
    int w0, d0;
    w0 = nwrites; d0 = ndone; max_hold = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = ADDR_W'($urandom); bus.word_count = 9'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("zero_done", 64'(ndone - d0), 64'd1);
    chk("zero_wr", 64'(nwrites - w0), 64'd0);
    chk("zero_hold", 64'(max_hold <= 1), 64'd1);
    chk("zero_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    logic [ADDR_W-1:0] base;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    for (int j = 0; j < MEM_SZ; j++) begin
      exp_mem[j] = 8'h00;
      act_mem[j] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init", outs(), 64'd0);
    rst = 1'b0;

    run_load(10'h000, 1, 0, 0, 32'h8C01_0004, 1'b0, -1);
    chk("b0", 64'(act_mem[0]), 64'h04);
    chk("b3", 64'(act_mem[3]), 64'h8C);
    run_load(10'h100, 3, 2, 2, $urandom, 1'b0, -1);
    run_bad(10'h000, 257);
    run_bad(10'h3FC, 2);
    run_zero();
    run_load(10'h040, 4, 0, 1, $urandom, 1'b0, 1);
    run_load(10'h080, 2, 0, 1, $urandom, 1'b0, -1);
    run_load(10'h200, 4, 0, 2, $urandom, 1'b1, -1);
    run_load(10'h3FC, 1, 0, 1, $urandom, 1'b0, -1);
    run_load(10'h000, 256, 0, 0, $urandom, 1'b0, -1);

    for (int n = 0; n < 6; n++) begin
      wc   = int'($urandom_range(6, 1));
      base = ADDR_W'($urandom_range(MEM_SZ - 4 * wc, 0));
      run_load(base, wc, 0, 3, $urandom, 1'b0, -1);
    end
    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        wc   = int'($urandom_range(511, 257));
        base = ADDR_W'($urandom);
      end else begin
        wc   = int'($urandom_range(256, 1));
        base = ADDR_W'($urandom_range(MEM_SZ - 1, MEM_SZ - 4 * wc + 1));
      end
      run_bad(base, wc);
    end
    run_zero();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
